gate_vector_sequencer: RTL and testbench

Sequencer that exhaustively drives all 2^N_IN input vectors into the three implementations of one logic gate (behavioural, dataflow, structural) and checks them against each other and, optionally, against a golden truth table. It sits between the lab harness and the gate instances: it owns the shared input bus to the gates, samples their three outputs, and reports pass/fail with a mismatch count. It replaces hand-written vector sequences with one reusable, clocked checker.

---
 rtl/gate_seq_pkg.sv | 24 ++
 rtl/gate_vector_sequencer_if.sv | 28 ++
 rtl/settle_timer.sv | 37 +++
 rtl/gate_vector_sequencer.sv | 136 +++++++++++++
 tb/tb_gate_vector_sequencer.sv | 210 +++++++++++++++++++++
 5 files changed

// File: rtl/gate_seq_pkg.sv
// Shared definitions for the gate vector sequencer: FSM encoding, settle
// counter width and the legal parameter ranges.
package gate_seq_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_APPLY  = 3'd1,
    ST_SETTLE = 3'd2,
    ST_CHECK  = 3'd3,
    ST_DONE   = 3'd4
  } state_e;

  localparam int SETTLE_W   = 4;
  localparam int N_IN_MIN   = 1;
  localparam int N_IN_MAX   = 4;
  localparam int SETTLE_MIN = 1;
  localparam int SETTLE_MAX = 15;

  function automatic bit cfg_legal(input int nIn, input int settle);
    return (nIn >= N_IN_MIN) && (nIn <= N_IN_MAX) &&
           (settle >= SETTLE_MIN) && (settle <= SETTLE_MAX);
  endfunction

endpackage

// File: rtl/gate_vector_sequencer_if.sv
// Bus between the lab harness / gate instances and the sequencer.
interface gate_vector_sequencer_if #(parameter int N_IN = 2);

  logic                   start;
  logic                   expected_en;
  logic [(1<<N_IN)-1:0]   golden;
  logic                   y_bh;
  logic                   y_df;
  logic                   y_st;
  logic [N_IN-1:0]        vec;
  logic                   busy;
  logic                   done;
  logic                   pass;
  logic [N_IN:0]          err_count;
  logic                   first_err_valid;
  logic [N_IN-1:0]        first_err_vec;

  modport master (
    output start, expected_en, golden, y_bh, y_df, y_st,
    input  vec, busy, done, pass, err_count, first_err_valid, first_err_vec
  );

  modport slave (
    input  start, expected_en, golden, y_bh, y_df, y_st,
    output vec, busy, done, pass, err_count, first_err_valid, first_err_vec
  );

endinterface

// File: rtl/settle_timer.sv
// Down-counter that holds a freshly applied vector for a fixed number of
// cycles; zero_o tells the sequencer the gate outputs may be sampled.
module settle_timer
  import gate_seq_pkg::*;
#(
  parameter int W = SETTLE_W
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load_i,
  input  logic [W-1:0] load_val_i,
  input  logic         dec_i,
  output logic         zero_o
);

  logic [W-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (load_i) begin
      count_d = load_val_i;
    end else if (dec_i && !zero_o) begin
      count_d = count_q - 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign zero_o = (count_q == '0);

endmodule

// File: rtl/gate_vector_sequencer.sv
// Walks every input vector through three implementations of one gate and
// records whether they agree with each other and, optionally, with a golden table.
module gate_vector_sequencer
  import gate_seq_pkg::*;
#(
  parameter int N_IN   = 2,
  parameter int SETTLE = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  gate_vector_sequencer_if.slave bus
);

  localparam logic [SETTLE_W-1:0] SettleLoad = SETTLE_W'(SETTLE - 1);

  generate
    if (!cfg_legal(N_IN, SETTLE)) begin : g_bad_cfg
      $error("gate_vector_sequencer: N_IN or SETTLE out of range");
    end
  endgenerate

  state_e            state_q, state_d;
  logic              timerLoad, timerDec, timerZero;
  logic [N_IN-1:0]   vec_q, vec_d;
  logic [N_IN-1:0]   firstErrVec_q, firstErrVec_d;
  logic [N_IN:0]     errCount_q, errCount_d;
  logic              firstErrValid_q, firstErrValid_d;
  logic              pass_q, pass_d;
  logic              expEn_q, expEn_d;
  logic              vecFail;
  logic              lastVec;

  settle_timer #(.W(SETTLE_W)) u_settle_timer (
    .clk        (clk),
    .rst        (rst),
    .load_i     (timerLoad),
    .load_val_i (SettleLoad),
    .dec_i      (timerDec),
    .zero_o     (timerZero)
  );

  assign lastVec = &vec_q;
  assign vecFail = (bus.y_bh != bus.y_df) || (bus.y_df != bus.y_st) ||
                   (expEn_q && (bus.y_bh != bus.golden[vec_q]));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE:   if (bus.start) state_d = ST_APPLY;
      ST_APPLY:  state_d = ST_SETTLE;
      ST_SETTLE: if (timerZero) state_d = ST_CHECK;
      ST_CHECK:  state_d = lastVec ? ST_DONE : ST_APPLY;
      ST_DONE:   state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    bus.busy  = (state_q == ST_APPLY) || (state_q == ST_SETTLE) ||
                (state_q == ST_CHECK);
    bus.done  = (state_q == ST_DONE);
    timerLoad = (state_q == ST_APPLY);
    timerDec  = (state_q == ST_SETTLE);
  end

  // pass is computed on the last CHECK so it is already valid alongside done.
  always_comb begin
    vec_d           = vec_q;
    errCount_d      = errCount_q;
    firstErrValid_d = firstErrValid_q;
    firstErrVec_d   = firstErrVec_q;
    pass_d          = pass_q;
    expEn_d         = expEn_q;
    unique case (state_q)
      ST_IDLE: begin
        if (bus.start) begin
          vec_d           = '0;
          errCount_d      = '0;
          firstErrValid_d = 1'b0;
          firstErrVec_d   = '0;
          pass_d          = 1'b0;
          expEn_d         = bus.expected_en;
        end
      end
      ST_CHECK: begin
        if (vecFail) begin
          errCount_d = errCount_q + 1'b1;
          if (!firstErrValid_q) begin
            firstErrValid_d = 1'b1;
            firstErrVec_d   = vec_q;
          end
        end
        if (lastVec) begin
          pass_d = (errCount_d == '0);
        end else begin
          vec_d = vec_q + 1'b1;
        end
      end
      default: begin
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vec_q           <= '0;
      errCount_q      <= '0;
      firstErrValid_q <= 1'b0;
      firstErrVec_q   <= '0;
      pass_q          <= 1'b0;
      expEn_q         <= 1'b0;
    end else begin
      vec_q           <= vec_d;
      errCount_q      <= errCount_d;
      firstErrValid_q <= firstErrValid_d;
      firstErrVec_q   <= firstErrVec_d;
      pass_q          <= pass_d;
      expEn_q         <= expEn_d;
    end
  end

  assign bus.vec             = vec_q;
  assign bus.err_count       = errCount_q;
  assign bus.first_err_valid = firstErrValid_q;
  assign bus.first_err_vec   = firstErrVec_q;
  assign bus.pass            = pass_q;

endmodule

// File: tb/tb_gate_vector_sequencer.sv
// Directed bench for gate_vector_sequencer: two configurations, OR gates
// with an optional faulty AND implementation, results checked via a scoreboard.
module tb_gate_vector_sequencer;

  localparam int NA    = 2;
  localparam int SA    = 1;
  localparam int PER_A = SA + 2;
  localparam int NB    = 3;
  localparam int SB    = 3;

  typedef struct {
    int errs;
    int fv;
    int fev;
    int pass;
    int cycles;
  } expRun_t;

  logic clk = 1'b0;
  logic rst;
  logic stAnd;
  int   errors = 0;
  int   checks = 0;
  int   cB;
  bit   seenB;
  expRun_t expQ[$];

  always #5 clk = ~clk;

  gate_vector_sequencer_if #(.N_IN(NA)) busA ();
  gate_vector_sequencer_if #(.N_IN(NB)) busB ();

  // Gate models under test: OR everywhere, optionally a wrong AND in the structural slot.
  assign busA.y_bh = |busA.vec;
  assign busA.y_df = |busA.vec;
  assign busA.y_st = stAnd ? &busA.vec : |busA.vec;
  assign busB.y_bh = |busB.vec;
  assign busB.y_df = |busB.vec;
  assign busB.y_st = |busB.vec;

  gate_vector_sequencer #(.N_IN(NA), .SETTLE(SA)) dutA (
    .clk (clk),
    .rst (rst),
    .bus (busA)
  );

  gate_vector_sequencer #(.N_IN(NB), .SETTLE(SB)) dutB (
    .clk (clk),
    .rst (rst),
    .bus (busB)
  );

  task automatic checkOutput(input string tag, input logic [31:0] obs,
                             input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic expRun_t modelRun(input int nIn, input int settle,
                                       input logic expEn, input logic [15:0] gold,
                                       input logic andSt);
    expRun_t r;
    logic orV, andV, stV, bad;
    r.errs = 0;
    r.fv   = 0;
    r.fev  = 0;
    for (int v = 0; v < (1 << nIn); v++) begin
      orV  = (v != 0);
      andV = (v == (1 << nIn) - 1);
      stV  = andSt ? andV : orV;
      bad  = (orV != stV) || (expEn && (orV != gold[v]));
      if (bad) begin
        if (r.fv == 0) begin
          r.fv  = 1;
          r.fev = v;
        end
        r.errs++;
      end
    end
    r.pass   = (r.errs == 0) ? 1 : 0;
    r.cycles = (1 << nIn) * (settle + 2);
    return r;
  endfunction

  task automatic checkDone(input string tag, input int cyc, input logic [31:0] ec,
                           input logic [31:0] fv, input logic [31:0] fev,
                           input logic [31:0] ps, output expRun_t e);
    if (expQ.size() == 0) begin
      checkOutput({tag, "_sbEmpty"}, 0, 1);
      e = '{0, 0, 0, 0, 0};
    end else begin
      e = expQ.pop_front();
      checkOutput({tag, "_doneCycle"}, cyc, e.cycles);
      checkOutput({tag, "_errCount"}, ec, e.errs);
      checkOutput({tag, "_firstErrValid"}, fv, e.fv);
      checkOutput({tag, "_firstErrVec"}, fev, e.fev);
      checkOutput({tag, "_pass"}, ps, e.pass);
    end
  endtask

  task automatic applyStimulus(input string tag, input logic expEn,
                               input logic [3:0] gold, input logic andSt,
                               input int abortAt, input bit repulse);
    bit      seen;
    expRun_t e;
    stAnd            = andSt;
    busA.expected_en = expEn;
    busA.golden      = gold;
    if (abortAt < 0) expQ.push_back(modelRun(NA, SA, expEn, 16'(gold), andSt));
    @(negedge clk);
    busA.start = 1'b1;
    @(posedge clk);
    seen = 1'b0;
    for (int c = 0; c < 40 && !seen; c++) begin
      @(negedge clk);
      busA.start = repulse && (c == 3 || c == 7);
      if (c == abortAt) begin
        rst = 1'b1;
        #1;
        checkOutput({tag, "_rstBusy"}, busA.busy, 0);
        checkOutput({tag, "_rstVec"}, busA.vec, 0);
        checkOutput({tag, "_rstErrCount"}, busA.err_count, 0);
        checkOutput({tag, "_rstFirstErrValid"}, busA.first_err_valid, 0);
        #2;
        rst = 1'b0;
        busA.start = 1'b0;
        return;
      end
      if (c == 0) begin
        checkOutput({tag, "_passCleared"}, busA.pass, 0);
        checkOutput({tag, "_errCleared"}, busA.err_count, 0);
      end
      if (busA.done) begin
        seen = 1'b1;
        checkDone(tag, c, busA.err_count, busA.first_err_valid,
                  busA.first_err_vec, busA.pass, e);
      end else if (c < 4 * PER_A) begin
        checkOutput({tag, "_vec"}, busA.vec, c / PER_A);
        checkOutput({tag, "_busy"}, busA.busy, 1);
      end
    end
    busA.start = 1'b0;
    if (!seen) begin
      checkOutput({tag, "_doneTimeout"}, 0, 1);
      return;
    end
    repeat (3) begin
      @(negedge clk);
      checkOutput({tag, "_doneOnePulse"}, busA.done, 0);
      checkOutput({tag, "_passHeld"}, busA.pass, e.pass);
      checkOutput({tag, "_vecHeld"}, busA.vec, 3);
    end
  endtask

  initial begin
    expRun_t eB;
    rst              = 1'b1;
    stAnd            = 1'b0;
    busA.start       = 1'b0;
    busA.expected_en = 1'b0;
    busA.golden      = '0;
    busB.start       = 1'b0;
    busB.expected_en = 1'b0;
    busB.golden      = '0;
    repeat (3) @(negedge clk);
    checkOutput("reset_vec", busA.vec, 0);
    checkOutput("reset_busy", busA.busy, 0);
    checkOutput("reset_done", busA.done, 0);
    checkOutput("reset_pass", busA.pass, 0);
    checkOutput("reset_errCount", busA.err_count, 0);
    checkOutput("reset_firstErrValid", busA.first_err_valid, 0);
    checkOutput("reset_firstErrVec", busA.first_err_vec, 0);
    checkOutput("resetB_busy", busB.busy, 0);
    rst = 1'b0;
    @(negedge clk);

    applyStimulus("orPass",   1'b1, 4'b1110, 1'b0, -1, 1'b0);
    applyStimulus("stAnd",    1'b1, 4'b1110, 1'b1, -1, 1'b0);
    applyStimulus("goldAnd",  1'b1, 4'b1000, 1'b0, -1, 1'b0);
    applyStimulus("noExpEn",  1'b0, 4'b1000, 1'b0, -1, 1'b0);
    applyStimulus("repulse",  1'b1, 4'b1110, 1'b0, -1, 1'b1);
    applyStimulus("abort",    1'b1, 4'b1110, 1'b1,  6, 1'b0);
    applyStimulus("afterRst", 1'b1, 4'b1110, 1'b0, -1, 1'b0);

    busB.expected_en = 1'b1;
    busB.golden      = 8'hFE;
    expQ.push_back(modelRun(NB, SB, 1'b1, 16'h00FE, 1'b0));
    @(negedge clk);
    busB.start = 1'b1;
    @(posedge clk);
    seenB = 1'b0;
    for (cB = 0; cB < 100 && !seenB; cB++) begin
      @(negedge clk);
      busB.start = 1'b0;
      if (busB.done) begin
        seenB = 1'b1;
        checkDone("n3s3", cB, busB.err_count, busB.first_err_valid,
                  busB.first_err_vec, busB.pass, eB);
      end
    end
    if (!seenB) checkOutput("n3s3_doneTimeout", 0, 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
